// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: holds the fetch PC, issues word reads over req/done and pushes results to the IQ.
// Define ICACHE_EN to add a direct-mapped one-word-per-line instruction cache in front of memory.
module if_fetch_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          ICACHE_LINES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IQ_full,
  output logic        IF_inst_valid,
  output logic [31:0] IF_inst,
  output logic [31:0] IF_pc,
  input  logic        jump_valid,
  input  logic [31:0] jump_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
);

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_bad_lines
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        discard, discard_nxt;
  logic        req_nxt, vld_nxt;
  logic [31:0] addr_nxt, inst_nxt, ipc_nxt;

`ifdef ICACHE_EN
  localparam int IDX_W = $clog2(ICACHE_LINES);
  localparam int TAG_W = 30 - IDX_W;

  logic [ICACHE_LINES-1:0] c_vld;
  logic [TAG_W-1:0]        c_tag  [ICACHE_LINES];
  logic [31:0]             c_data [ICACHE_LINES];
  logic [IDX_W-1:0]        rd_idx, wr_idx;
  logic                    hit, fill;

  assign rd_idx = pc[IDX_W+1:2];
  assign wr_idx = mem_addr[IDX_W+1:2];
  assign hit    = c_vld[rd_idx] && (c_tag[rd_idx] == pc[31:IDX_W+2]);
`endif

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    discard_nxt = discard;
    req_nxt     = mem_req;
    addr_nxt    = mem_addr;
    vld_nxt     = 1'b0;
    inst_nxt    = IF_inst;
    ipc_nxt     = IF_pc;
`ifdef ICACHE_EN
    fill        = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (jump_valid) begin
          pc_nxt = jump_pc;
        end else if (!IQ_full) begin
`ifdef ICACHE_EN
          if (hit) begin
            vld_nxt  = 1'b1;
            inst_nxt = c_data[rd_idx];
            ipc_nxt  = pc;
            pc_nxt   = pc + 32'd4;
          end else
`endif
          begin
            req_nxt   = 1'b1;
            addr_nxt  = pc;
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (mem_done) begin
          req_nxt     = 1'b0;
          discard_nxt = 1'b0;
          state_nxt   = IDLE;
          if (jump_valid) begin
            pc_nxt = jump_pc;
          end else if (!discard) begin
            vld_nxt  = 1'b1;
            inst_nxt = mem_data;
            ipc_nxt  = mem_addr;
            pc_nxt   = pc + 32'd4;
`ifdef ICACHE_EN
            fill     = 1'b1;
`endif
          end
        end else if (jump_valid) begin
          // request can't be aborted; remember to drop its data when it lands
          pc_nxt      = jump_pc;
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      pc            <= RESET_PC;
      discard       <= 1'b0;
      mem_req       <= 1'b0;
      mem_addr      <= 32'h0;
      IF_inst_valid <= 1'b0;
      IF_inst       <= 32'h0;
      IF_pc         <= 32'h0;
    end else if (rdy) begin
      state         <= state_nxt;
      pc            <= pc_nxt;
      discard       <= discard_nxt;
      mem_req       <= req_nxt;
      mem_addr      <= addr_nxt;
      IF_inst_valid <= vld_nxt;
      IF_inst       <= inst_nxt;
      IF_pc         <= ipc_nxt;
    end
  end

`ifdef ICACHE_EN
  always_ff @(posedge clk) begin
    if (!rst)                c_vld         <= '0;
    else if (rdy && fill)    c_vld[wr_idx] <= 1'b1;
  end

  // tag/data arrays carry no reset so they can map onto RAM
  always_ff @(posedge clk) begin
    if (rst && rdy && fill) begin
      c_tag[wr_idx]  <= mem_addr[31:IDX_W+2];
      c_data[wr_idx] <= mem_data;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Randomized self-checking bench for if_fetch_ctrl with a cycle-level reference model and a latency-variable memory.
module tb_if_fetch_ctrl;
  localparam logic [31:0] RPC   = 32'h0;
  localparam int          LINES = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0, rdy = 1'b1, IQ_full = 1'b0, jump_valid = 1'b0;
  logic [31:0] jump_pc = 32'h0;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = 32'h0;
  logic        IF_inst_valid, mem_req;
  logic [31:0] IF_inst, IF_pc, mem_addr;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.RESET_PC(RPC), .ICACHE_LINES(LINES)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .IQ_full(IQ_full),
    .IF_inst_valid(IF_inst_valid), .IF_inst(IF_inst), .IF_pc(IF_pc),
    .jump_valid(jump_valid), .jump_pc(jump_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data)
  );

  int n_cmp = 0, n_err = 0;
  bit chk_en = 1'b0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A1234;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: accepts a request once, answers after a latency, then waits for req to drop
  bit m_busy = 1'b0, m_wl = 1'b0;
  int m_cnt = 0, lat_fix = 2;
  always @(posedge clk) begin
    #3;
    mem_done = 1'b0;
    mem_data = $urandom;
    if (!rst) begin
      m_busy = 1'b0;
      m_wl   = 1'b0;
    end else begin
      if (!mem_req) m_wl = 1'b0;
      if (mem_req && !m_busy && !m_wl) begin
        m_busy = 1'b1;
        m_cnt  = (lat_fix >= 0) ? lat_fix : int'($urandom_range(4, 0));
      end
      if (m_busy && rdy) begin
        if (m_cnt == 0) begin
          mem_done = 1'b1;
          mem_data = mem_fn(mem_addr);
          m_busy   = 1'b0;
          m_wl     = 1'b1;
        end else m_cnt--;
      end
    end
  end

  // reference model: "waiting" means a memory read is outstanding
  logic        md_wait, md_disc, md_req, md_vld;
  logic [31:0] md_pc, md_addr, md_inst, md_ipc;
`ifdef ICACHE_EN
  logic        bm_v [LINES];
  logic [31:0] bm_a [LINES];
  logic [31:0] bm_d [LINES];
  function automatic int cidx(input logic [31:0] a);
    return int'((a >> 2) % 32'(LINES));
  endfunction
`endif

  always @(posedge clk) begin
    if (!rst) begin
      md_pc <= RPC; md_wait <= 1'b0; md_disc <= 1'b0; md_req <= 1'b0;
      md_addr <= 32'h0; md_vld <= 1'b0; md_inst <= 32'h0; md_ipc <= 32'h0;
`ifdef ICACHE_EN
      for (int i = 0; i < LINES; i++) bm_v[i] <= 1'b0;
`endif
    end else if (rdy) begin
      md_vld <= 1'b0;
      if (!md_wait) begin
        if (jump_valid) md_pc <= jump_pc;
        else if (!IQ_full) begin
`ifdef ICACHE_EN
          if (bm_v[cidx(md_pc)] && bm_a[cidx(md_pc)] == md_pc) begin
            md_vld <= 1'b1; md_inst <= bm_d[cidx(md_pc)]; md_ipc <= md_pc; md_pc <= md_pc + 32'd4;
          end else
`endif
          begin
            md_req <= 1'b1; md_addr <= md_pc; md_wait <= 1'b1;
          end
        end
      end else if (mem_done) begin
        md_req <= 1'b0; md_wait <= 1'b0; md_disc <= 1'b0;
        if (jump_valid) md_pc <= jump_pc;
        else if (!md_disc) begin
          md_vld <= 1'b1; md_inst <= mem_data; md_ipc <= md_addr; md_pc <= md_pc + 32'd4;
`ifdef ICACHE_EN
          bm_v[cidx(md_addr)] <= 1'b1; bm_a[cidx(md_addr)] <= md_addr; bm_d[cidx(md_addr)] <= mem_data;
`endif
        end
      end else if (jump_valid) begin
        md_pc <= jump_pc; md_disc <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 32'(IF_inst_valid), 32'(md_vld));
      check("req", 32'(mem_req), 32'(md_req));
      check("addr", mem_addr, md_addr);
      check("if_pc", IF_pc, md_ipc);
      check("if_inst", IF_inst, md_inst);
      if (IF_inst_valid) check("inst_vs_mem", IF_inst, mem_fn(IF_pc));
    end
  end

  // advances to the next negedge where the condition holds; 0 valid, 1 req high, 2 req low, 3 done
  task automatic wait_until(input int what, input int bound, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if ((what == 0 && IF_inst_valid) || (what == 1 && mem_req) ||
          (what == 2 && !mem_req) || (what == 3 && mem_done)) begin
        ok = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL timeout %s: condition %0d not seen in %0d cycles, required within bound", name, what, bound);
    end
  endtask

  initial begin
    logic [31:0] a;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 32'(IF_inst_valid), 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_pc", IF_pc, 32'h0);
    check("rst_inst", IF_inst, 32'h0);

    @(posedge clk); #2; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("first_req", 32'(mem_req), 32'h1);
    check("first_addr", mem_addr, 32'h0);
    wait_until(0, 30, "push0");
    check("push0_pc", IF_pc, 32'h0);
    check("push0_inst", IF_inst, mem_fn(32'h0));

    IQ_full = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("full_noreq", 32'(mem_req), 32'h0);
    end
    IQ_full = 1'b0;
    @(negedge clk);
    check("full_rel_req", 32'(mem_req), 32'h1);
    check("full_rel_addr", mem_addr, 32'h4);

    wait_until(0, 30, "push4");
    check("push4_pc", IF_pc, 32'h4);
    lat_fix = 4;
    wait_until(1, 10, "req8");
    check("req8_addr", mem_addr, 32'h8);
    jump_valid = 1'b1; jump_pc = 32'h100;
    @(negedge clk);
    jump_valid = 1'b0;
    wait_until(2, 30, "req8_drop");
    wait_until(1, 10, "req100");
    check("jw_addr", mem_addr, 32'h100);
    wait_until(0, 30, "push100");
    check("jw_pc", IF_pc, 32'h100);

    lat_fix = 2;
    wait_until(3, 30, "done_jd");
    jump_valid = 1'b1; jump_pc = 32'h200;
    @(negedge clk);
    jump_valid = 1'b0;
    check("jd_novalid", 32'(IF_inst_valid), 32'h0);
    wait_until(1, 10, "req200");
    check("jd_addr", mem_addr, 32'h200);
    wait_until(0, 30, "push200");
    check("jd_pc", IF_pc, 32'h200);

    lat_fix = 8;
    wait_until(1, 10, "req_rdy");
    @(negedge clk);
    a = mem_addr;
    check("rdy_addr0", a, 32'h204);
    rdy = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rdy_req_hold", 32'(mem_req), 32'h1);
      check("rdy_addr_hold", mem_addr, a);
    end
    rdy = 1'b1;
    wait_until(0, 30, "push_rdy");
    check("rdy_push_pc", IF_pc, a);
    wait_until(1, 10, "req_after_rdy");
    check("rdy_next_addr", mem_addr, a + 32'd4);

`ifdef ICACHE_EN
    lat_fix = 1;
    wait_until(0, 30, "pre_loop");
    jump_valid = 1'b1; jump_pc = 32'h0;
    @(negedge clk);
    jump_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_until(0, 30, "loop1");
      check("loop1_pc", IF_pc, 32'(4 * i));
    end
    jump_valid = 1'b1; jump_pc = 32'h0;
    @(negedge clk);
    jump_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hit_valid", 32'(IF_inst_valid), 32'h1);
      check("hit_pc", IF_pc, 32'(4 * i));
      check("hit_noreq", 32'(mem_req), 32'h0);
    end
`endif

    lat_fix = -1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      rst        = ($urandom_range(299, 0) != 0);
      rdy        = ($urandom_range(9, 0) != 0);
      IQ_full    = ($urandom_range(3, 0) == 0);
      jump_valid = ($urandom_range(11, 0) == 0);
      jump_pc    = ($urandom_range(3, 0) == 0) ? (32'hFFFFFFF0 + (32'($urandom_range(3, 0)) << 2))
                                               : (32'($urandom_range(31, 0)) << 2);
    end
    @(posedge clk); #2;
    rst = 1'b1; rdy = 1'b1; jump_valid = 1'b0; IQ_full = 1'b0;
    repeat (20) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_ctrl.md
# if_fetch_ctrl

Instruction-fetch controller sitting between the memory controller and the instruction queue. It holds the architectural fetch PC and issues word reads to the memory controller through a req/done handshake. It pushes each returned instruction into the queue with a one-cycle valid pulse, throttled by the queue's full flag, and redirects on jumps from the commit/branch logic. An optional direct-mapped instruction cache lets hits bypass memory.

## Interface
- `RESET_PC`, default 32'h0, fetch PC loaded on reset.
- `ICACHE_LINES`, default 16, number of cache lines, each holding one 32-bit word; must be a power of two; ignored without `ICACHE_EN`.

- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset: state resets on a rising edge with `rst`==0.
- `rdy`  in  1  global enable; when 0, all state and outputs hold.
- `IQ_full`  in  1  queue full flag; fetch may not launch while 1.
- `IF_inst_valid`  out  1  one-cycle push strobe to the queue.
- `IF_inst`  out  32  instruction word.
- `IF_pc`  out  32  PC of `IF_inst`.
- `jump_valid`  in  1  redirect request, one-cycle pulse.
- `jump_pc`  in  32  redirect target, word-aligned.
- `mem_req`  out  1  read request, held until `mem_done`.
- `mem_addr`  out  32  read address, stable while `mem_req`=1.
- `mem_done`  in  1  one-cycle completion pulse.
- `mem_data`  in  32  read data, valid with `mem_done`.

## Operation
- Reset values:
  - `IF_inst_valid`=0, `IF_inst`=0, `IF_pc`=0, `mem_req`=0, `mem_addr`=0.
  - Fetch PC=`RESET_PC`, state=IDLE, discard flag=0.
  - All cache valid bits=0.
- The state machine has two states, IDLE and WAIT.
- IDLE, in priority order:
  - `jump_valid`: PC<=`jump_pc`, stay IDLE, no push.
  - Else `IQ_full`=1: stay IDLE.
  - Else cache hit (`ICACHE_EN` only): `IF_inst`<=line data, `IF_pc`<=PC, `IF_inst_valid`<=1, PC<=PC+4, stay IDLE.
  - Else: `mem_req`<=1, `mem_addr`<=PC, go WAIT.
- WAIT:
  - `jump_valid` without `mem_done`: PC<=`jump_pc`, discard<=1, stay WAIT, keep `mem_req` high. The outstanding request is never aborted.
  - `mem_done` with discard=0 and no `jump_valid`:
    - push `mem_data` with `IF_pc`=`mem_addr`;
    - PC<=PC+4; fill the cache line;
    - `mem_req`<=0, go IDLE.
  - `mem_done` with discard=1 or same-cycle `jump_valid`:
    - drop the data, no push, no cache fill;
    - if `jump_valid` is also high, PC<=`jump_pc`;
    - discard<=0, `mem_req`<=0, go IDLE.
- `IF_inst_valid` is deasserted in every cycle where no push occurs.
- PC arithmetic is 32-bit modulo; 32'hFFFFFFFC+4 wraps to 0.
- `IQ_full` is checked only at launch. An in-flight fetch always completes its push, relying on the queue's two-slot full margin.
- A jump pulse arriving while `IQ_full`=1 is still taken.

## Timing
- Miss path:
  - launch decision in cycle N; `mem_req`/`mem_addr` valid from N+1;
  - `mem_done` in cycle M (M≥N+1); `IF_inst_valid` high in M+1;
  - `mem_req` low in M+1.
- Minimum one IDLE cycle between consecutive memory requests.
- Hit path: decision in cycle N, push visible in N+1. Back-to-back hits sustain one instruction per cycle.
- Redirect:
  - a jump in cycle N (IDLE) makes the first fetch from `jump_pc` launch in N+1;
  - a jump in WAIT takes effect after the outstanding `mem_done`.
- With `rdy`=0, no state changes and `mem_req` holds. `mem_done` must not arrive during `rdy`=0.
- Reset mid-WAIT returns to IDLE with `mem_req`=0. The memory controller is reset by the same `rst`.

## Configuration
- `ICACHE_EN`, when defined:
  - direct-mapped cache of `ICACHE_LINES` words;
  - index = PC[log2(`ICACHE_LINES`)+1:2], tag = remaining upper PC bits;
  - filled on every non-discarded `mem_done`;
  - valid bits are cleared only by reset (no invalidation on jump);
  - hits follow the IDLE hit rule.
- When undefined: no cache storage, every fetch goes through memory, and the hit branch is absent.

## Test plan
- Reset with `RESET_PC`=0, memory latency 3 → `mem_req`=1 with `mem_addr`=0 the cycle after reset release. `IF_inst_valid` pulses with `IF_pc`=0, then the next request is to address 4.
- `IQ_full`=1 held for 10 cycles from IDLE → `mem_req` stays 0. After release, a fetch launches the next cycle.
- `jump_valid` with `jump_pc`=32'h100 during WAIT for address 8 → the data for address 8 is not pushed. The next `mem_addr` is 32'h100, and `IF_pc`=32'h100 is pushed.
- `jump_valid` in the same cycle as `mem_done` → the data is dropped and PC=`jump_pc`. No `IF_inst_valid` pulse occurs.
- With `ICACHE_EN`, a loop over 0x0–0xC, then a jump to 0x0 → the second pass shows no `mem_req` and four consecutive `IF_inst_valid` cycles with PCs 0, 4, 8, C.
- `rdy`=0 for 5 cycles mid-WAIT → `mem_req`, `mem_addr` and the PC are unchanged. Fetching resumes correctly afterwards.
